keypad_password_collector: RTL and testbench

//  Upstream stage of the parking-gate controller. Collects keypad presses into a
//  NUM_DIGITS-digit BCD password. Supports backspace, clear and enter, plus an

---
 rtl/keypad_password_collector.sv | 120 ++++++++++++
 tb/tb_keypad_password_collector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_password_collector.sv
// Collects keypad digits into a BCD password with backspace, clear, enter and an
// inactivity timeout; publishes accepted passwords with a one-cycle strobe.
module keypad_password_collector #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned TMO_W          = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    output logic [4*NUM_DIGITS-1:0] password_out,
    output logic                    password_valid,
    output logic                    entry_error,
    output logic [2:0]              digit_count,
    output logic                    busy
);

    localparam int unsigned     W         = 4 * NUM_DIGITS;
    localparam logic [2:0]      FullCount = 3'(NUM_DIGITS);
    localparam logic [TMO_W-1:0] TmoLast  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StEntry, StFull} state_e;

    state_e           state;
    logic [W-1:0]     shift_buf;
    logic [TMO_W-1:0] tmo;
    logic             key_acc;
    logic             is_digit;

    always_comb begin
        key_acc  = key_valid & enable;
        is_digit = (key_code <= 4'd9);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            shift_buf      <= '0;
            tmo            <= '0;
            password_out   <= '0;
            password_valid <= 1'b0;
            entry_error    <= 1'b0;
            digit_count    <= '0;
            busy           <= 1'b0;
        end else begin
            password_valid <= 1'b0;
            entry_error    <= 1'b0;
            case (state)
                StIdle: begin
                    tmo <= '0;
                    if (key_acc && is_digit) begin
                        shift_buf   <= W'(key_code);
                        digit_count <= 3'd1;
                        state       <= (NUM_DIGITS == 1) ? StFull : StEntry;
                        busy        <= 1'b1;
                    end
                end
                default: begin
                    if (!enable) begin
                        // Losing enable abandons the entry silently.
                        shift_buf   <= '0;
                        digit_count <= '0;
                        tmo         <= '0;
                        state       <= StIdle;
                        busy        <= 1'b0;
                    end else if (key_valid) begin
                        tmo <= '0;
                        if (is_digit) begin
                            if (state == StEntry) begin
                                shift_buf   <= (shift_buf << 4) | W'(key_code);
                                digit_count <= digit_count + 3'd1;
                                if (digit_count + 3'd1 == FullCount) state <= StFull;
                            end
                        end else begin
                            case (key_code)
                                4'hA: begin
                                    shift_buf   <= shift_buf >> 4;
                                    digit_count <= digit_count - 3'd1;
                                    if (digit_count == 3'd1) begin
                                        state <= StIdle;
                                        busy  <= 1'b0;
                                    end else begin
                                        state <= StEntry;
                                    end
                                end
                                4'hB, 4'hC: begin
                                    if (key_code == 4'hB) begin
                                        if (state == StFull) begin
                                            password_out   <= shift_buf;
                                            password_valid <= 1'b1;
                                        end else begin
                                            entry_error <= 1'b1;
                                        end
                                    end
                                    shift_buf   <= '0;
                                    digit_count <= '0;
                                    state       <= StIdle;
                                    busy        <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end else if (tmo == TmoLast) begin
                        entry_error <= 1'b1;
                        shift_buf   <= '0;
                        digit_count <= '0;
                        tmo         <= '0;
                        state       <= StIdle;
                        busy        <= 1'b0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_password_collector.sv
// Directed bench for keypad_password_collector; strobes are checked against a
// queue of expected events filled as enter keys and timeouts are provoked.
module tb_keypad_password_collector;

    localparam int unsigned T = 1000;

    typedef struct packed {
        logic        is_err;
        logic [15:0] pw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [15:0] password_out;
    logic        password_valid;
    logic        entry_error;
    logic [2:0]  digit_count;
    logic        busy;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    logic [15:0] pw_model = 16'h0;

    keypad_password_collector #(
        .NUM_DIGITS    (4),
        .TIMEOUT_CYCLES(T),
        .TMO_W         (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .password_out  (password_out),
        .password_valid(password_valid),
        .entry_error   (entry_error),
        .digit_count   (digit_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_pw(input logic [15:0] pw);
        pw_model = pw;
        exp_q.push_back('{is_err: 1'b0, pw: pw});
    endtask

    task automatic expect_err();
        exp_q.push_back('{is_err: 1'b1, pw: pw_model});
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t item;
        if (!rst && (password_valid || entry_error)) begin
            chk("strobe_exclusive", {31'b0, password_valid & entry_error}, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {30'b0, password_valid, entry_error}, 0);
            end else begin
                item = exp_q.pop_front();
                chk("strobe_kind", {31'b0, entry_error}, {31'b0, item.is_err});
                chk("strobe_password_out", {16'b0, password_out}, {16'b0, item.pw});
            end
        end
    end

    initial begin
        #12;
        chk("reset_password_out", {16'b0, password_out}, 0);
        chk("reset_strobes", {30'b0, password_valid, entry_error}, 0);
        chk("reset_digit_count", {29'b0, digit_count}, 0);
        chk("reset_busy", {31'b0, busy}, 0);
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b1;

        // Basic four-digit password
        press(4'h3); press(4'h7); press(4'h6); press(4'h1);
        chk("t1_count_full", {29'b0, digit_count}, 4);
        chk("t1_busy", {31'b0, busy}, 1);
        expect_pw(16'h3761);
        press(4'hB);
        chk("t1_count_after", {29'b0, digit_count}, 0);
        chk("t1_idle", {31'b0, busy}, 0);
        chk("t1_password_out", {16'b0, password_out}, 32'h3761);

        // Backspace drops the last digit
        press(4'h1); press(4'h2); press(4'hA);
        chk("t2_count_bs", {29'b0, digit_count}, 1);
        press(4'h5); press(4'h8); press(4'h9);
        expect_pw(16'h1589);
        press(4'hB);
        chk("t2_password_out", {16'b0, password_out}, 32'h1589);

        // Short enter is an error and leaves password_out alone
        press(4'h4); press(4'h4);
        expect_err();
        press(4'hB);
        chk("t3_password_out", {16'b0, password_out}, 32'h1589);
        chk("t3_idle", {31'b0, busy}, 0);

        // Non-digit keys in IDLE do nothing
        press(4'hA); press(4'hB); press(4'hC); press(4'hE);
        chk("idle_ignore_count", {29'b0, digit_count}, 0);
        chk("idle_ignore_busy", {31'b0, busy}, 0);

        // Extra digit in FULL is ignored
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h9);
        chk("t4_count_full", {29'b0, digit_count}, 4);
        expect_pw(16'h1234);
        press(4'hB);
        chk("t4_password_out", {16'b0, password_out}, 32'h1234);

        // Backspace from FULL, then clear
        press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'hA);
        chk("full_bs_count", {29'b0, digit_count}, 3);
        press(4'hC);
        chk("clear_count", {29'b0, digit_count}, 0);
        chk("clear_busy", {31'b0, busy}, 0);

        // Timeout after T idle cycles
        @(negedge clk); key_valid = 1'b1; key_code = 4'h7;
        @(negedge clk); key_valid = 1'b0;
        repeat (T - 1) @(negedge clk);
        chk("t5_busy_before_tmo", {31'b0, busy}, 1);
        expect_err();
        @(negedge clk);
        chk("t5_busy_after_tmo", {31'b0, busy}, 0);
        chk("t5_count_after_tmo", {29'b0, digit_count}, 0);

        // Key at the terminal count wins and restarts the timer
        @(negedge clk); key_valid = 1'b1; key_code = 4'h7;
        @(negedge clk); key_valid = 1'b0;
        repeat (T - 1) @(negedge clk);
        key_valid = 1'b1; key_code = 4'h8;
        @(negedge clk); key_valid = 1'b0;
        chk("t5_key_wins_count", {29'b0, digit_count}, 2);
        chk("t5_key_wins_err", {31'b0, entry_error}, 0);
        repeat (T - 1) @(negedge clk);
        chk("t5_restart_busy", {31'b0, busy}, 1);
        expect_err();
        @(negedge clk);
        chk("t5_restart_tmo", {31'b0, busy}, 0);

        // Dropping enable abandons entry, keys ignored while disabled
        press(4'h1); press(4'h2);
        enable = 1'b0;
        @(negedge clk);
        chk("en_drop_count", {29'b0, digit_count}, 0);
        chk("en_drop_busy", {31'b0, busy}, 0);
        press(4'h5);
        chk("en_low_ignored", {29'b0, digit_count}, 0);
        chk("en_drop_pw_held", {16'b0, password_out}, 32'h1234);
        enable = 1'b1;

        // Asynchronous reset mid-entry
        press(4'h1); press(4'h2);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_count", {29'b0, digit_count}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_password_out", {16'b0, password_out}, 0);
        chk("rst_strobes", {30'b0, password_valid, entry_error}, 0);
        pw_model = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        chk("pending_strobes", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
